vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-002 Parameters SHALL be:
- TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before automatic refund.
- MOTOR_CYCLES, default 4: dispense motor pulse length.
- STOCK_INIT, default 15 (max 15): per-drink stock loaded by reset and restock.

REQ-003 Ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- coin  in  2  01=1, 10=2, 11=5, 00=none; at most one coin per cycle.
- select  in  2  00=Coke(5), 01=Pepsi(7), 10=Sprite(10), 11=invalid.
- confirm  in  1  one-cycle purchase request.
- cancel  in  1  one-cycle refund request.
- restock  in  1  one-cycle pulse; reload all stock.
- motor_on  out  1  dispense motor drive.
- motor_sel  out  2  drink being dispensed.
- payout_coin  out  2  one-cycle change coin, same encoding as coin.
- coin_reject  out  1  one-cycle pulse; coin not accepted.
- error  out  1  one-cycle pulse; confirm refused.
- busy  out  1  high when state is not IDLE.
- balance  out  5  current credit.
- sold_out  out  3  bit i high when stock of drink i is 0.

Function
REQ-004 The state machine SHALL have the states IDLE, COLLECT, VEND and PAYOUT; all registered outputs are updated on the clk rising edge.
REQ-005 IDLE: a nonzero coin SHALL load its value into balance and move to COLLECT; confirm and cancel are ignored; restock reloads all three stock counters to STOCK_INIT.
REQ-006 COLLECT: a coin SHALL add its value to balance; a coin that would push balance above 31 is not added and pulses coin_reject.
REQ-007 COLLECT confirm, evaluated against the balance before any same-cycle coin, SHALL pulse error and stay in COLLECT if select==11, the selected stock is 0, or balance < price.
REQ-008 Otherwise confirm SHALL subtract price from balance, decrement the selected stock, latch motor_sel and move to VEND.
REQ-009 cancel in COLLECT SHALL move to PAYOUT; cancel SHALL win over a simultaneous confirm.
REQ-010 A timeout counter SHALL clear on any coin or confirm in COLLECT; on reaching TIMEOUT_CYCLES the block moves to PAYOUT.
REQ-011 VEND: motor_on SHALL be high for exactly MOTOR_CYCLES cycles, starting the cycle after the accepted confirm; afterwards go to PAYOUT if balance > 0, else IDLE.
REQ-012 PAYOUT: each cycle SHALL emit the largest coin <= balance (5, then 2, then 1) on payout_coin and subtract its value; when balance reaches 0, return to IDLE with payout_coin = 00.
REQ-013 Coins arriving in VEND or PAYOUT SHALL NOT be added and SHALL pulse coin_reject; restock outside IDLE SHALL be ignored.
REQ-014 Stock counters SHALL be 4 bits and SHALL never decrement below 0; busy and sold_out are combinational decodes of state and stock.

Reset
REQ-015 While reset is high, all outputs SHALL be 0 (including motor_on, asynchronously) and balance and the counters SHALL be 0.
REQ-016 On reset, state SHALL go to IDLE and every stock counter SHALL be loaded with STOCK_INIT.
REQ-017 Reset during VEND or PAYOUT SHALL discard the credit; no refund is owed after reset.

Structure
REQ-018 A shared package vend_pkg SHALL hold the coin codes, drink codes, prices (5/7/10), the state enum and a coin-value function.
REQ-019 Greedy change selection and balance decrement SHALL live in the sub-module vend_payout_unit; the remaining logic stays in vend_controller.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Coins 5 then 5, select=01, confirm -> motor_on 4 cycles with motor_sel=01; then payout_coin 10, 01 in consecutive cycles; back to IDLE.
- Coin 2, select=00, confirm -> error pulse, balance stays 2; then cancel -> payout_coin 10; IDLE.
- Coins totalling 30, then coin 2 -> coin_reject pulse, balance 30; cancel -> payout of six 5-coins.
- Stock of drink 10 driven to 0 by repeated purchases -> sold_out[2]=1; further confirm on 10 -> error; restock in IDLE -> sold_out[2]=0.
- Coin 1, no activity for TIMEOUT_CYCLES -> PAYOUT, payout_coin 01; same cycle confirm+cancel -> refund, no motor.
- reset asserted during VEND cycle 2 -> motor_on low immediately; after release: IDLE, balance 0, stock at STOCK_INIT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin and drink codes, prices,
// FSM state constants and small decode helpers.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam logic [1:0] DRINK_COKE    = 2'b00;
  localparam logic [1:0] DRINK_PEPSI   = 2'b01;
  localparam logic [1:0] DRINK_SPRITE  = 2'b10;
  localparam logic [1:0] DRINK_INVALID = 2'b11;

  localparam logic [4:0] PRICE_COKE   = 5'd5;
  localparam logic [4:0] PRICE_PEPSI  = 5'd7;
  localparam logic [4:0] PRICE_SPRITE = 5'd10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_VEND    = 2'd2;
  localparam state_t ST_PAYOUT  = 2'd3;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 5'd1;
      COIN_2:  return 5'd2;
      COIN_5:  return 5'd5;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] drink_price(input logic [1:0] drink);
    case (drink)
      DRINK_COKE:   return PRICE_COKE;
      DRINK_PEPSI:  return PRICE_PEPSI;
      DRINK_SPRITE: return PRICE_SPRITE;
      default:      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_payout_unit.sv
// Greedy change selection: picks the largest coin not exceeding the balance
// and returns the balance left after paying it out.
module vend_payout_unit
  import vend_pkg::*;
(
  input  logic [4:0] balance,
  output logic [1:0] coin,
  output logic [4:0] balance_next
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    coin = COIN_NONE;
    if (balance >= 5'd5)      coin = COIN_5;
    else if (balance >= 5'd2) coin = COIN_2;
    else if (balance != 5'd0) coin = COIN_1;
    balance_next = balance - coin_value(coin);
  end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: coin collection, purchase checks, timed motor
// pulse, greedy change payout and per-drink stock tracking.
module vend_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MOTOR_CYCLES   = 4,
  parameter int STOCK_INIT     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic [1:0] select,
  input  logic       confirm,
  input  logic       cancel,
  input  logic       restock,
  output logic       motor_on,
  output logic [1:0] motor_sel,
  output logic [1:0] payout_coin,
  output logic       coin_reject,
  output logic       error,
  output logic       busy,
  output logic [4:0] balance,
  output logic [2:0] sold_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MW = $clog2(MOTOR_CYCLES + 1);
  localparam logic [3:0]    STOCK_LOAD   = 4'(STOCK_INIT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MOTOR_LAST   = MW'(MOTOR_CYCLES - 1);

  state_t            state_q, state_d;
  logic [4:0]        balance_q, balance_d;
  logic [2:0][3:0]   stock_q, stock_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [MW-1:0]     mcnt_q, mcnt_d;
  logic              motor_on_q, motor_on_d;
  logic [1:0]        motor_sel_q, motor_sel_d;
  logic [1:0]        payout_coin_q, payout_coin_d;
  logic              coin_reject_q, coin_reject_d;
  logic              error_q, error_d;

  logic [4:0] coin_val, price, base_bal;
  logic [5:0] sum_bal;
  logic       sel_avail;
  logic [1:0] pay_coin;
  logic [4:0] pay_next;

  vend_payout_unit u_payout (
    .balance      (balance_q),
    .coin         (pay_coin),
    .balance_next (pay_next)
  );

  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    stock_d       = stock_q;
    timer_d       = timer_q;
    mcnt_d        = mcnt_q;
    motor_on_d    = 1'b0;
    motor_sel_d   = motor_sel_q;
    payout_coin_d = COIN_NONE;
    coin_reject_d = 1'b0;
    error_d       = 1'b0;
    coin_val      = coin_value(coin);
    price         = drink_price(select);
    base_bal      = balance_q;
    sum_bal       = '0;
    sel_avail     = 1'b0;
    for (int i = 0; i < 3; i++)
      if (select == 2'(i)) sel_avail = (stock_q[i] != 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (restock) stock_d = {3{STOCK_LOAD}};
        if (coin != COIN_NONE) begin
          balance_d = coin_val;
          timer_d   = '0;
          state_d   = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          state_d = ST_PAYOUT;
        end else if (confirm) begin
          // Purchase is judged on the credit held before any same-cycle coin.
          if (sel_avail && balance_q >= price) begin
            base_bal = balance_q - price;
            for (int i = 0; i < 3; i++)
              if (select == 2'(i)) stock_d[i] = stock_q[i] - 4'd1;
            motor_on_d  = 1'b1;
            motor_sel_d = select;
            mcnt_d      = '0;
            state_d     = ST_VEND;
          end else begin
            error_d = 1'b1;
          end
        end
        balance_d = base_bal;
        if (coin != COIN_NONE) begin
          sum_bal = {1'b0, base_bal} + {1'b0, coin_val};
          if (sum_bal[5]) coin_reject_d = 1'b1;
          else            balance_d     = sum_bal[4:0];
        end
        if (coin != COIN_NONE || confirm) begin
          timer_d = '0;
        end else if (!cancel) begin
          if (timer_q == TIMEOUT_LAST) state_d = ST_PAYOUT;
          else                         timer_d = timer_q + 1'b1;
        end
      end

      ST_VEND: begin
        coin_reject_d = (coin != COIN_NONE);
        if (mcnt_q == MOTOR_LAST) begin
          state_d = (balance_q != 5'd0) ? ST_PAYOUT : ST_IDLE;
        end else begin
          mcnt_d     = mcnt_q + 1'b1;
          motor_on_d = 1'b1;
        end
      end

      default: begin
        coin_reject_d = (coin != COIN_NONE);
        payout_coin_d = pay_coin;
        balance_d     = pay_next;
        if (pay_next == 5'd0) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      balance_q     <= '0;
      stock_q       <= {3{STOCK_LOAD}};
      timer_q       <= '0;
      mcnt_q        <= '0;
      motor_on_q    <= 1'b0;
      motor_sel_q   <= DRINK_COKE;
      payout_coin_q <= COIN_NONE;
      coin_reject_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      balance_q     <= balance_d;
      stock_q       <= stock_d;
      timer_q       <= timer_d;
      mcnt_q        <= mcnt_d;
      motor_on_q    <= motor_on_d;
      motor_sel_q   <= motor_sel_d;
      payout_coin_q <= payout_coin_d;
      coin_reject_q <= coin_reject_d;
      error_q       <= error_d;
    end
  end

  assign motor_on    = motor_on_q;
  assign motor_sel   = motor_sel_q;
  assign payout_coin = payout_coin_q;
  assign coin_reject = coin_reject_q;
  assign error       = error_q;
  assign balance     = balance_q;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    for (int i = 0; i < 3; i++) sold_out[i] = (stock_q[i] == 4'd0);
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural machine model.
module tb_vend_controller;

  localparam int T_CYC  = 40;
  localparam int M_CYC  = 4;
  localparam int S_INIT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin, select;
  logic       confirm, cancel, restock;
  logic       motor_on;
  logic [1:0] motor_sel, payout_coin;
  logic       coin_reject, error, busy;
  logic [4:0] balance;
  logic [2:0] sold_out;

  vend_controller #(
    .TIMEOUT_CYCLES (T_CYC),
    .MOTOR_CYCLES   (M_CYC),
    .STOCK_INIT     (S_INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .select      (select),
    .confirm     (confirm),
    .cancel      (cancel),
    .restock     (restock),
    .motor_on    (motor_on),
    .motor_sel   (motor_sel),
    .payout_coin (payout_coin),
    .coin_reject (coin_reject),
    .error       (error),
    .busy        (busy),
    .balance     (balance),
    .sold_out    (sold_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: credit, stock, remaining motor cycles, and whether the
  // machine is collecting coins or handing back change.
  int  m_credit, m_motor_left, m_idle, m_sel, m_pay;
  int  m_stock[3];
  bit  m_collect, m_refund, m_motor, m_rej, m_err;
  int  den[3] = '{5, 2, 1};

  // Run statistics for directed scenarios.
  int st_motor, st_p5, st_p2, st_p1, st_err, st_rej;

  function automatic int cval(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_motor_left = 0; m_idle = 0; m_sel = 0; m_pay = 0;
    m_collect = 0; m_refund = 0; m_motor = 0; m_rej = 0; m_err = 0;
    for (int i = 0; i < 3; i++) m_stock[i] = S_INIT;
  endfunction

  function automatic void model_step(input logic [1:0] c, input logic [1:0] s,
                                     input logic cf, input logic cn, input logic rs);
    int cv, price;
    bit avail;
    cv    = cval(c);
    price = (s == 0) ? 5 : (s == 1) ? 7 : (s == 2) ? 10 : 0;
    avail = 0;
    if (s != 3) avail = m_stock[s] > 0;
    m_pay = 0; m_rej = 0; m_err = 0;
    if (m_motor_left > 0) begin
      m_rej = (cv != 0);
      m_motor_left--;
      m_motor = (m_motor_left > 0);
      if (m_motor_left == 0) m_refund = (m_credit > 0);
    end else if (m_refund) begin
      m_rej = (cv != 0);
      for (int i = 0; i < 3; i++)
        if (m_pay == 0 && den[i] <= m_credit) m_pay = den[i];
      m_credit -= m_pay;
      if (m_credit == 0) m_refund = 0;
    end else if (m_collect) begin
      if (cn) begin
        m_collect = 0; m_refund = 1;
      end else if (cf) begin
        if (!avail || m_credit < price) m_err = 1;
        else begin
          m_credit -= price; m_stock[s]--; m_sel = s;
          m_motor_left = M_CYC; m_motor = 1; m_collect = 0;
        end
      end
      if (cv != 0) begin
        if (m_credit + cv > 31) m_rej = 1;
        else                    m_credit += cv;
      end
      if (cv != 0 || cf) m_idle = 0;
      else if (!cn) begin
        m_idle++;
        if (m_idle == T_CYC) begin m_collect = 0; m_refund = 1; end
      end
    end else begin
      if (rs) for (int i = 0; i < 3; i++) m_stock[i] = S_INIT;
      if (cv != 0) begin m_credit = cv; m_collect = 1; m_idle = 0; end
    end
  endfunction

  task automatic compare_all();
    check("motor_on",    motor_on,          m_motor);
    check("motor_sel",   motor_sel,         m_sel);
    check("payout",      cval(payout_coin), m_pay);
    check("coin_reject", coin_reject,       m_rej);
    check("error",       error,             m_err);
    check("busy",        busy,              (m_collect || m_refund || m_motor_left > 0));
    check("balance",     balance,           m_credit);
    check("sold_out",    sold_out,          {m_stock[2] == 0, m_stock[1] == 0, m_stock[0] == 0});
  endtask

  task automatic clear_stats();
    st_motor = 0; st_p5 = 0; st_p2 = 0; st_p1 = 0; st_err = 0; st_rej = 0;
  endtask

  // One clock: drive inputs at the falling edge, step the model, then sample at the next falling edge.
  task automatic cyc(input logic [1:0] c, input logic [1:0] s,
                     input logic cf, input logic cn, input logic rs);
    coin = c; select = s; confirm = cf; cancel = cn; restock = rs;
    model_step(c, s, cf, cn, rs);
    @(negedge clk);
    compare_all();
    if (motor_on) st_motor++;
    if (error) st_err++;
    if (coin_reject) st_rej++;
    case (payout_coin)
      2'b11:   st_p5++;
      2'b10:   st_p2++;
      2'b01:   st_p1++;
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 200) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check("drain_to_idle", busy, 0);
  endtask

  task automatic do_reset(input int hold);
    coin = 2'b00; select = 2'b00; confirm = 0; cancel = 0; restock = 0;
    reset = 1'b1;
    #1;
    check("rst_motor_on",   motor_on,    0);
    check("rst_motor_sel",  motor_sel,   0);
    check("rst_payout",     payout_coin, 0);
    check("rst_reject",     coin_reject, 0);
    check("rst_error",      error,       0);
    check("rst_busy",       busy,        0);
    check("rst_balance",    balance,     0);
    check("rst_sold_out",   sold_out,    0);
    repeat (hold) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    do_reset(3);

    // 5+5, Pepsi: motor 4 cycles, then change 2 and 1.
    clear_stats();
    cyc(2'b11, 2'b01, 0, 0, 0);
    cyc(2'b11, 2'b01, 0, 0, 0);
    cyc(2'b00, 2'b01, 1, 0, 0);
    check("s1_motor_start", motor_on, 1);
    check("s1_motor_sel", motor_sel, 2'b01);
    check("s1_balance_after_buy", balance, 3);
    drain();
    check("s1_motor_cycles", st_motor, M_CYC);
    check("s1_pay_2", st_p2, 1);
    check("s1_pay_1", st_p1, 1);
    check("s1_pay_5", st_p5, 0);

    // Coin 2, Coke: refused, then cancel refunds a 2-coin.
    clear_stats();
    cyc(2'b10, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 1, 0, 0);
    check("s2_error_pulse", error, 1);
    check("s2_balance_kept", balance, 2);
    cyc(2'b00, 2'b00, 0, 1, 0);
    drain();
    check("s2_refund_2", st_p2, 1);
    check("s2_motor_never", st_motor, 0);

    // Credit 30, extra 2 rejected, cancel pays six 5-coins.
    clear_stats();
    repeat (6) cyc(2'b11, 2'b00, 0, 0, 0);
    check("s3_balance_30", balance, 30);
    cyc(2'b10, 2'b00, 0, 0, 0);
    check("s3_reject_pulse", coin_reject, 1);
    check("s3_balance_held", balance, 30);
    cyc(2'b00, 2'b00, 0, 1, 0);
    drain();
    check("s3_six_fives", st_p5, 6);
    check("s3_reject_count", st_rej, 1);

    // Empty the Sprite slot, refused purchase, restock clears sold_out.
    for (int i = 0; i < S_INIT; i++) begin
      cyc(2'b11, 2'b10, 0, 0, 0);
      cyc(2'b11, 2'b10, 0, 0, 0);
      cyc(2'b00, 2'b10, 1, 0, 0);
      drain();
    end
    check("s4_sold_out", sold_out[2], 1);
    cyc(2'b11, 2'b10, 0, 0, 0);
    cyc(2'b11, 2'b10, 0, 0, 0);
    cyc(2'b00, 2'b10, 1, 0, 0);
    check("s4_error_on_empty", error, 1);
    cyc(2'b00, 2'b00, 0, 1, 0);
    drain();
    cyc(2'b00, 2'b00, 0, 0, 1);
    check("s4_restocked", sold_out[2], 0);

    // Timeout refund, then confirm+cancel together refunds without vending.
    clear_stats();
    cyc(2'b01, 2'b00, 0, 0, 0);
    idle(T_CYC);
    check("s5_timeout_no_pay_yet", st_p1, 0);
    check("s5_timeout_busy", busy, 1);
    cyc(2'b00, 2'b00, 0, 0, 0);
    check("s5_timeout_pay_1", payout_coin, 2'b01);
    drain();
    clear_stats();
    cyc(2'b11, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 1, 1, 0);
    drain();
    check("s5_cancel_wins_motor", st_motor, 0);
    check("s5_cancel_wins_pay", st_p5, 1);
    check("s5_cancel_wins_err", st_err, 0);

    // Reset in the second motor cycle.
    cyc(2'b11, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 1, 0, 0);
    cyc(2'b00, 2'b00, 0, 0, 0);
    check("s6_motor_before_reset", motor_on, 1);
    do_reset(2);
    @(negedge clk);
    compare_all();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset(1);
      else cyc(($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00,
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
